// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the 32-point FFT memory sequencer.
package fft_pkg;

    localparam int FFT_N      = 32;
    localparam int LOG2N      = 5;
    localparam int NUM_STAGES = 5;
    localparam int NUM_BFLY   = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        UNLOAD,
        DONE
    } state_t;

endpackage

// File: rtl/fft_bfly_addr_gen.sv
// Radix-2 in-place butterfly addressing: maps (stage, butterfly index) to the
// G/H memory addresses and the twiddle ROM index. Purely combinational.
module fft_bfly_addr_gen
    import fft_pkg::*;
(
    input  logic [2:0]       stage,
    input  logic [3:0]       k,
    output logic [LOG2N-1:0] g,
    output logic [LOG2N-1:0] h,
    output logic [3:0]       tw
);

    logic [4:0] kx;
    logic [4:0] span;
    logic [4:0] msk;
    logic [3:0] klo;

    // G inserts a zero at bit position 'stage'; H sets that bit; twiddle scales the low bits
    always_comb begin
        kx   = {1'b0, k};
        span = 5'd1 << stage;
        msk  = span - 5'd1;
        g    = ((kx >> stage) << (stage + 3'd1)) | (kx & msk);
        h    = g + span;
        klo  = k & msk[3:0];
        tw   = klo << (3'd4 - stage);
    end

endmodule

// File: rtl/fft_mem_ctrl.sv
// Sequencer for the 32-point in-place FFT memory: load, five butterfly stages
// with alternating read/write address phases, then natural-order unload.
// Optional macro FFT_CTRL_PERF_CNT_EN enables the busy-cycle counter on
// cycle_count; without it cycle_count is tied to zero.
module fft_mem_ctrl
    import fft_pkg::*;
#(
    parameter int N      = 32,
    parameter int WR_LAG = 2,
    parameter int RD_LAT = 2
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             load_data_write,
    output logic [LOG2N-1:0] load_data_addr,
    output logic             bank0_write_en,
    output logic             bank1_write_en,
    output logic             rw_addr_en,
    output logic             bank_read_sel,
    output logic [LOG2N-1:0] read_G_addr,
    output logic [LOG2N-1:0] read_H_addr,
    output logic [LOG2N-1:0] write_G_addr,
    output logic [LOG2N-1:0] write_H_addr,
    output logic [3:0]       twiddle_addr,
    output logic             out_valid,
    output logic [LOG2N-1:0] out_index,
    output logic             busy,
    output logic             done,
    output logic [15:0]      cycle_count
);

    localparam logic [LOG2N-1:0] LAST_IDX   = LOG2N'(N - 1);
    localparam int               SLOTS      = NUM_BFLY + WR_LAG;
    localparam logic [4:0]       LAST_SLOT  = 5'(SLOTS - 1);
    localparam logic [2:0]       LAST_STAGE = 3'(NUM_STAGES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       stage;
    logic [4:0]       slot;
    logic             phase;
    logic [LOG2N-1:0] cnt;
    logic             rd_on;

    logic             vld_p [RD_LAT];
    logic [LOG2N-1:0] idx_p [RD_LAT];

    logic             rd_ok;
    logic             wr_ok;
    logic [3:0]       rd_k;
    logic [3:0]       wr_k;
    logic [5:0]       wr_diff;
    logic [LOG2N-1:0] rd_g;
    logic [LOG2N-1:0] rd_h;
    logic [LOG2N-1:0] wr_g;
    logic [LOG2N-1:0] wr_h;
    logic [3:0]       rd_tw;
    logic [3:0]       wr_tw_unused;
    logic             res_vld;
    logic             last_out;

    // Reads cover slots 0..15; writes trail by WR_LAG slots (borrow means "not yet")
    assign rd_k     = slot[3:0];
    assign rd_ok    = ~slot[4];
    assign wr_diff  = {1'b0, slot} - 6'(WR_LAG);
    assign wr_ok    = (wr_diff[5:4] == 2'b00);
    assign wr_k     = wr_diff[3:0];
    assign res_vld  = (state == UNLOAD) && vld_p[RD_LAT-1];
    assign last_out = res_vld && (idx_p[RD_LAT-1] == LAST_IDX);

    fft_bfly_addr_gen u_rd_addr (
        .stage (stage),
        .k     (rd_k),
        .g     (rd_g),
        .h     (rd_h),
        .tw    (rd_tw)
    );

    fft_bfly_addr_gen u_wr_addr (
        .stage (stage),
        .k     (wr_k),
        .g     (wr_g),
        .h     (wr_h),
        .tw    (wr_tw_unused)
    );

    // State register
    always_ff @(posedge clk) begin
        if (clear) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode and all memory-control outputs
    always_comb begin
        state_nxt       = state;
        in_ready        = 1'b0;
        load_data_write = 1'b0;
        load_data_addr  = '0;
        bank0_write_en  = 1'b0;
        bank1_write_en  = 1'b0;
        rw_addr_en      = 1'b0;
        bank_read_sel   = 1'b0;
        read_G_addr     = '0;
        read_H_addr     = '0;
        write_G_addr    = '0;
        write_H_addr    = '0;
        twiddle_addr    = '0;
        out_valid       = 1'b0;
        out_index       = '0;
        busy            = 1'b0;
        done            = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                busy            = 1'b1;
                in_ready        = 1'b1;
                load_data_write = 1'b1;
                load_data_addr  = cnt;
                bank0_write_en  = in_valid;
                if (in_valid && (cnt == LAST_IDX)) state_nxt = COMPUTE;
            end
            COMPUTE: begin
                busy          = 1'b1;
                rw_addr_en    = phase;
                bank_read_sel = stage[0];
                if (!phase && rd_ok) begin
                    read_G_addr  = rd_g;
                    read_H_addr  = rd_h;
                    twiddle_addr = rd_tw;
                end
                if (phase && wr_ok) begin
                    write_G_addr   = wr_g;
                    write_H_addr   = wr_h;
                    bank0_write_en = stage[0];
                    bank1_write_en = ~stage[0];
                end
                if (phase && (slot == LAST_SLOT) && (stage == LAST_STAGE)) state_nxt = UNLOAD;
            end
            UNLOAD: begin
                busy          = 1'b1;
                bank_read_sel = 1'b1;
                if (rd_on) read_G_addr = cnt;
                out_valid = res_vld;
                if (res_vld) out_index = idx_p[RD_LAT-1];
                if (last_out) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sample/unload counter and stage/slot/phase sequencing
    always_ff @(posedge clk) begin
        if (clear) begin
            stage <= '0;
            slot  <= '0;
            phase <= 1'b0;
            cnt   <= '0;
            rd_on <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        if (cnt == LAST_IDX) cnt <= '0;
                        else                 cnt <= cnt + LOG2N'(1);
                    end
                end
                COMPUTE: begin
                    phase <= ~phase;
                    if (phase) begin
                        if (slot == LAST_SLOT) begin
                            slot <= '0;
                            if (stage == LAST_STAGE) begin
                                stage <= '0;
                                cnt   <= '0;
                                rd_on <= 1'b1;
                            end else begin
                                stage <= stage + 3'd1;
                            end
                        end else begin
                            slot <= slot + 5'd1;
                        end
                    end
                end
                UNLOAD: begin
                    if (rd_on) begin
                        if (cnt == LAST_IDX) rd_on <= 1'b0;
                        else                 cnt   <= cnt + LOG2N'(1);
                    end
                end
                default: begin
                    stage <= '0;
                    slot  <= '0;
                    phase <= 1'b0;
                    cnt   <= '0;
                    rd_on <= 1'b0;
                end
            endcase
        end
    end

    // Unload valid follows each read address by RD_LAT cycles
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < RD_LAT; i++) vld_p[i] <= 1'b0;
        end else begin
            vld_p[0] <= (state == UNLOAD) && rd_on;
            for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    // Result index travels alongside its valid
    always_ff @(posedge clk) begin
        idx_p[0] <= cnt;
        for (int i = 1; i < RD_LAT; i++) idx_p[i] <= idx_p[i-1];
    end

`ifdef FFT_CTRL_PERF_CNT_EN
    logic [15:0] perf_cnt;

    // Busy-cycle counter: restarts on start acceptance, holds after done
    always_ff @(posedge clk) begin
        if (clear)                         perf_cnt <= '0;
        else if ((state == IDLE) && start) perf_cnt <= '0;
        else if (busy)                     perf_cnt <= perf_cnt + 16'd1;
    end

    assign cycle_count = perf_cnt;
`else
    assign cycle_count = '0;
`endif

endmodule

// File: doc/fft_mem_ctrl.md
Name: fft_mem_ctrl

Overview:
- Sequencer for the 32-point radix-2 in-place FFT memory (two ping-pong banks, G/H dual ports).
- Drives every control and address input of the memory block: sample load, 5 butterfly stages with alternating read/write phases, then result unload.
- Also issues twiddle ROM addresses and busy/done status to the top level.

Parameters:
- N, 32, FFT length; power of two; memory address width is LOG2N = 5.
- WR_LAG, 2, butterfly-pipeline latency in slots: writes for butterfly k issue in the write phase of slot k+WR_LAG. Legal range 0..7.
- RD_LAT, 2, cycles from read address to memory output valid (RAM read plus output mux register).

Ports:
- clk  in  1  system clock
- clear  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a transform from IDLE
- in_valid  in  1  input sample present on the memory data inputs this cycle
- in_ready  out  1  controller accepts samples (LOAD state)
- load_data_write  out  1  memory in load mode
- load_data_addr  out  5  natural-order sample index
- bank0_write_en  out  1  bank 0 write enable
- bank1_write_en  out  1  bank 1 write enable
- rw_addr_en  out  1  0 = read-address phase, 1 = write-address phase
- bank_read_sel  out  1  bank feeding the G/H outputs
- read_G_addr, read_H_addr  out  5 each  butterfly read addresses
- write_G_addr, write_H_addr  out  5 each  butterfly write addresses
- twiddle_addr  out  4  twiddle ROM index for the butterfly being read
- out_valid  out  1  G_real/G_imag carry result word out_index
- out_index  out  5  natural-order index of the current result
- busy  out  1  high from start acceptance until DONE
- done  out  1  one-cycle pulse at end of unload
- cycle_count  out  16  performance counter (see Optional Feature)

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0. Reset mid-operation aborts immediately: write enables are 0 in the following cycle and no done pulse is generated.
- States: IDLE -> LOAD -> COMPUTE -> UNLOAD -> DONE -> IDLE.
- IDLE:
  - start=1 moves to LOAD next cycle and sets busy.
  - start while busy is ignored.
- LOAD:
  - in_ready=1, load_data_write=1, load_data_addr = sample counter.
  - bank0_write_en = in_valid; the counter increments only on in_valid.
  - Gaps in in_valid are allowed.
  - After the accept with counter=31, go to COMPUTE (stage 0, slot 0).
  - in_valid outside LOAD is ignored.
- COMPUTE:
  - Stage s runs 0..4. Each stage has 16+WR_LAG slots; each slot is 2 cycles: phase 0 (rw_addr_en=0), then phase 1 (rw_addr_en=1).
  - Address rule for butterfly k (0..15): span = 1<<s; G = ((k>>s)<<(s+1)) | (k & (span-1)); H = G+span; twiddle = (k & (span-1)) << (4-s).
  - Phase 0 of slot j with j<16: read_G/H_addr = addresses of butterfly j; twiddle_addr valid.
  - Phase 1 of slot j with j>=WR_LAG: write_G/H_addr = addresses of butterfly j-WR_LAG. Write enable asserts only in that phase, on bank (s+1)%2.
  - bank_read_sel = s[0] throughout the stage.
  - Stage boundary: s increments and slot resets to 0. After stage 4 completes, go to UNLOAD.
  - Cycles per stage = 2*(16+WR_LAG), i.e. 36 at default.
- UNLOAD:
  - bank_read_sel=1; read_G_addr = 0..31, one per cycle, with rw_addr_en=0.
  - out_valid/out_index follow each address by exactly RD_LAT cycles; there is no back-pressure.
  - Leave UNLOAD after the last out_valid.
- DONE: done=1 for one cycle, busy drops the same cycle, then return to IDLE.
- Counter wrap: 5-bit and slot counters never wrap within a state; all terminal values are checked explicitly.

Optional Feature:
- Macro FFT_CTRL_PERF_CNT_EN.
- Defined: cycle_count clears on start acceptance, increments every cycle while busy, and holds its value after done until the next start.
- Undefined: cycle_count is tied to 0 and no counter logic is generated.

Decomposition:
- Package fft_pkg: N, LOG2N, number of stages (5), butterflies per stage (16), and the state enum (IDLE, LOAD, COMPUTE, UNLOAD, DONE).
- Sub-module fft_bfly_addr_gen: purely combinational (stage, k) -> G, H, twiddle. Instantiated twice, once for the read index and once for the lagged write index.

Test Plan:
- Reset, then start, then 32 back-to-back in_valid:
  - load_data_addr steps 0..31 with bank0_write_en=1 each cycle.
  - COMPUTE entered the cycle after sample 31.
- Stage 0, slot 3, phase 0: read_G=6, read_H=7, twiddle=0.
- Stage 2, slot 5, phase 0: read_G=9, read_H=13, twiddle=4.
- Stage 4, slot 7, phase 1 (WR_LAG=2): write_G=5, write_H=21, bank1_write_en=1.
- Full run with PERF_CNT_EN and uninterrupted load:
  - exactly 32 out_valid pulses with out_index 0..31.
  - done once.
  - cycle_count = 32+180+32+RD_LAT+1 (±1 per the documented boundary).
- clear asserted in stage 2 mid-slot:
  - next cycle all enables 0, busy=0, state IDLE.
  - A following start restarts from LOAD with sample counter 0.
